// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO between the fetch PC/ROM and IF/ID; define FETCH_BYPASS_EN for same-cycle empty-queue bypass.
module fetch_queue #(
   parameter int ADDR_W   = 6,
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 4,
   parameter int RESET_PC = 0
) (
   input  logic                       clk,
   input  logic                       resetIn,
   input  logic                       enable,
   input  logic                       redirect,
   input  logic [ADDR_W-1:0]          redirectAddr,
   output logic [ADDR_W-1:0]          romAddr,
   input  logic [DATA_W-1:0]          romInst,
   output logic                       outValid,
   input  logic                       outReady,
   output logic [ADDR_W-1:0]          outAddr,
   output logic [DATA_W-1:0]          outInst,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [ADDR_W-1:0] fetchPC;
   logic [PW-1:0]     rdPtr, wrPtr;
   logic [ADDR_W-1:0] memAddr [DEPTH];
   logic [DATA_W-1:0] memInst [DEPTH];
   logic empty, full, advance, bypass, pop, push, popQ, writeQ;
   always_comb begin
      empty   = count == '0;
      full    = count == CW'(DEPTH);
      advance = enable & ~redirect;
`ifdef FETCH_BYPASS_EN
      bypass  = empty & advance;
`else
      bypass  = 1'b0;
`endif
      outValid = ~empty | bypass;
      outAddr  = !empty ? memAddr[rdPtr] : bypass ? fetchPC : '0;
      outInst  = !empty ? memInst[rdPtr] : bypass ? romInst : '0;
      pop      = advance & outValid & outReady;
      push     = advance & (~full | pop);
      // a bypassed entry that is consumed immediately never touches the storage
      popQ     = pop & ~empty;
      writeQ   = push & ~(empty & pop);
      romAddr  = fetchPC;
   end
   always_ff @(posedge clk) begin
      if (resetIn) begin
         fetchPC <= ADDR_W'(RESET_PC);
         rdPtr   <= '0;
         wrPtr   <= '0;
         count   <= '0;
      end else if (enable) begin
         if (redirect) begin
            fetchPC <= redirectAddr;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
         end else begin
            if (push) fetchPC <= fetchPC + 1'b1;
            if (writeQ) wrPtr <= wrPtr + 1'b1;
            if (popQ) rdPtr <= rdPtr + 1'b1;
            count <= count + CW'(writeQ) - CW'(popQ);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!resetIn && writeQ) begin
         memAddr[wrPtr] <= fetchPC;
         memInst[wrPtr] <= romInst;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table-driven directed check of fetch_queue against hand-computed cycle expectations.
module tb_fetch_queue;
   typedef struct {
      logic       rst, en, rd;
      logic [5:0] rdA;
      logic       rdy;
      logic       v;
      logic [5:0] a;
      logic [2:0] c;
      logic [5:0] rom;
   } vec_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic        resetIn, enable, redirect, outValid, outReady;
   logic [5:0]  redirectAddr, romAddr, outAddr;
   logic [31:0] romInst, outInst;
   logic [2:0]  count;
   int checks = 0, errors = 0;
   vec_t vecs[$];
   assign romInst = 32'hC0DE0000 | 32'(romAddr);
   fetch_queue dut (
      .clk(clk), .resetIn(resetIn), .enable(enable), .redirect(redirect),
      .redirectAddr(redirectAddr), .romAddr(romAddr), .romInst(romInst),
      .outValid(outValid), .outReady(outReady), .outAddr(outAddr),
      .outInst(outInst), .count(count)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic add(input logic rst, en, rd, input logic [5:0] rdA, input logic rdy,
                      input logic v, input logic [5:0] a, input logic [2:0] c, input logic [5:0] rom);
      vec_t t;
      t.rst = rst; t.en = en; t.rd = rd; t.rdA = rdA; t.rdy = rdy;
      t.v = v; t.a = a; t.c = c; t.rom = rom;
      vecs.push_back(t);
   endtask
   initial begin
      resetIn = 1'b1; enable = 1'b1; redirect = 1'b0; redirectAddr = '0; outReady = 1'b1;
      @(posedge clk); #1;
`ifndef FETCH_BYPASS_EN
      add(1,1,0,0,1, 0,0,0,0);
      add(0,1,0,0,1, 0,0,0,0);
      for (int i = 0; i < 4; i++) add(0,1,0,0,1, 1,6'(i),1,6'(i+1));
      add(0,1,0,0,0, 1,4,1,5);
      add(0,1,0,0,0, 1,4,2,6);
      add(0,1,0,0,0, 1,4,3,7);
      for (int i = 0; i < 5; i++) add(0,1,0,0,0, 1,4,4,8);
      for (int i = 0; i < 5; i++) add(0,1,0,0,1, 1,6'(4+i),4,6'(8+i));
      add(0,1,0,0,0, 1,9,4,13);
      add(0,1,1,6'h20,1, 1,9,4,13);
      add(0,1,0,0,1, 0,0,0,6'h20);
      add(0,1,0,0,1, 1,6'h20,1,6'h21);
      add(0,1,0,0,1, 1,6'h21,1,6'h22);
      add(0,1,1,6'h3E,1, 1,6'h22,1,6'h23);
      add(0,1,0,0,1, 0,0,0,6'h3E);
      add(0,1,0,0,1, 1,6'h3E,1,6'h3F);
      add(0,1,0,0,1, 1,6'h3F,1,6'h00);
      add(0,1,0,0,1, 1,6'h00,1,6'h01);
      add(0,1,0,0,1, 1,6'h01,1,6'h02);
      add(0,0,1,6'h10,1, 1,6'h02,1,6'h03);
      add(0,0,0,0,1, 1,6'h02,1,6'h03);
      add(0,0,1,6'h10,1, 1,6'h02,1,6'h03);
      add(0,1,0,0,1, 1,6'h02,1,6'h03);
      add(0,1,0,0,1, 1,6'h03,1,6'h04);
      add(0,1,0,0,0, 1,6'h04,1,6'h05);
      add(0,1,0,0,1, 1,6'h04,2,6'h06);
      add(0,1,0,0,1, 1,6'h05,2,6'h07);
`else
      add(1,1,0,0,1, 0,0,0,0);
      add(0,1,0,0,1, 1,0,0,0);
      add(0,1,0,0,1, 1,1,0,1);
      add(0,1,0,0,0, 1,2,0,2);
      add(0,1,0,0,1, 1,2,1,3);
      add(0,1,0,0,1, 1,3,1,4);
`endif
      foreach (vecs[i]) begin
         resetIn = vecs[i].rst; enable = vecs[i].en; redirect = vecs[i].rd;
         redirectAddr = vecs[i].rdA; outReady = vecs[i].rdy;
         @(negedge clk);
         chk($sformatf("v%0d valid", i), 32'(outValid), 32'(vecs[i].v));
         chk($sformatf("v%0d addr", i), 32'(outAddr), 32'(vecs[i].a));
         chk($sformatf("v%0d inst", i), outInst, vecs[i].v ? 32'hC0DE0000 | 32'(vecs[i].a) : 32'h0);
         chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].c));
         chk($sformatf("v%0d romAddr", i), 32'(romAddr), 32'(vecs[i].rom));
         @(posedge clk); #1;
      end
`ifndef FETCH_BYPASS_EN
      redirect = 1'b0; enable = 1'b1; outReady = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (count == 3'd4) break;
      end
      chk("fullWait count", 32'(count), 32'd4);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("fullHold romAddr", 32'(romAddr), 32'd10);
      chk("fullHold outAddr", 32'(outAddr), 32'd6);
      chk("fullHold count", 32'(count), 32'd4);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
